// File: rtl/acca_pkg.sv
// Shared mode encoding and tile-mode selection for the approximate tiled multiplier.
package acca_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_EXACT = 2'd0;
  localparam mode_t MODE_AP1   = 2'd1;
  localparam mode_t MODE_AP2   = 2'd2;
  localparam mode_t MODE_RSV   = 2'd3;

  // The lowest and highest significance classes get their own mode; everything between shares one.
  function automatic mode_t tile_mode(input int k, input int t,
                                      input mode_t lo, input mode_t mid, input mode_t hi);
    if (k == 0)
      return lo;
    else if (k == 2 * (t - 1))
      return hi;
    else
      return mid;
  endfunction

endpackage

// File: rtl/acca_tile4.sv
// Combinational 4x4 unsigned multiplier whose low product bits can be truncated by mode.
module acca_tile4
  import acca_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  mode_t      i_mode,
  output logic [7:0] o_p
);

  logic [7:0] w_exact;

  assign w_exact = i_a * i_b;

  always_comb begin
    o_p = w_exact;
    case (i_mode)
      MODE_AP1: o_p = {w_exact[7:2], 2'b00};
      MODE_AP2: o_p = {w_exact[7:3], 3'b000};
      default:  o_p = w_exact;
    endcase
  end

endmodule

// File: rtl/acca_pipe.sv
// Three-stage approximate multiplier: operand/mode register, tile-product register, sum register.
// Handshake: a beat moves on in_valid && in_ready; a result moves on out_valid && out_ready.
module acca_pipe
  import acca_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  mode_t            mode_lo,
  input  mode_t            mode_mid,
  input  mode_t            mode_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   prod,
  output logic [CNT_W-1:0] op_count
);

  localparam int T  = N / 4;
  localparam int NT = T * T;
  localparam int PW = 2 * N;

  logic             r_v1, r_v2, r_v3;
  logic [N-1:0]     r_a, r_b;
  mode_t            r_mode_lo, r_mode_mid, r_mode_hi;
  logic [7:0]       r_tile [NT];
  logic [PW-1:0]    r_prod;
  logic [CNT_W-1:0] r_cnt;

  logic             w_adv;
  logic             w_acc;
  logic [7:0]       w_tile [NT];
  logic [PW-1:0]    w_sum;

  // The whole pipe moves in lockstep, so one stall signal freezes every stage and bubble.
  assign w_adv = !r_v3 || out_ready;
  assign w_acc = in_valid && w_adv;

  for (genvar gi = 0; gi < T; gi++) begin : g_row
    for (genvar gj = 0; gj < T; gj++) begin : g_col
      mode_t w_mode;
      assign w_mode = tile_mode(gi + gj, T, r_mode_lo, r_mode_mid, r_mode_hi);
      acca_tile4 u_tile (
        .i_a    (r_a[4*gi +: 4]),
        .i_b    (r_b[4*gj +: 4]),
        .i_mode (w_mode),
        .o_p    (w_tile[gi*T+gj])
      );
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < T; i++) begin
      for (int j = 0; j < T; j++) begin
        w_sum = w_sum + (PW'(r_tile[i*T+j]) << (4 * (i + j)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_mode_lo  <= MODE_EXACT;
      r_mode_mid <= MODE_EXACT;
      r_mode_hi  <= MODE_EXACT;
      r_prod     <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < NT; i++) r_tile[i] <= '0;
    end else begin
      if (w_adv) begin
        r_v1       <= in_valid;
        r_a        <= a;
        r_b        <= b;
        r_mode_lo  <= mode_lo;
        r_mode_mid <= mode_mid;
        r_mode_hi  <= mode_hi;
        r_v2       <= r_v1;
        for (int i = 0; i < NT; i++) r_tile[i] <= w_tile[i];
        r_v3       <= r_v2;
        r_prod     <= w_sum;
      end
      if (w_acc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign prod      = r_prod;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_acca_pipe.sv
// Randomized and directed bench for acca_pipe against a nibble-arithmetic reference model.
module tb_acca_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic [1:0]  mode_lo = '0, mode_mid = '0, mode_hi = '0;
  logic        in_ready, out_valid;
  logic [15:0] prod;
  logic [15:0] op_count;
  logic        c4_in_ready, c4_out_valid;
  logic [15:0] c4_prod;
  logic [3:0]  c4_op_count;

  logic [15:0] exp_q[$];
  int          cyc_q[$];
  int          n_chk = 0, n_bad = 0;
  int          cyc = 0, n_acc = 0, last_lat = 0;
  logic [15:0] last_prod = '0, prev_prod = '0;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  acca_pipe #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode_lo(mode_lo), .mode_mid(mode_mid), .mode_hi(mode_hi),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .op_count(op_count)
  );

  acca_pipe #(.N(8), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c4_in_ready),
    .a(a), .b(b), .mode_lo(mode_lo), .mode_mid(mode_mid), .mode_hi(mode_hi),
    .out_valid(c4_out_valid), .out_ready(out_ready), .prod(c4_prod), .op_count(c4_op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sum of per-tile nibble products, each truncated by its class mode, weighted by 16^k.
  function automatic logic [15:0] model(input logic [7:0] ta, input logic [7:0] tb_,
                                        input logic [1:0] lo, input logic [1:0] mid,
                                        input logic [1:0] hi);
    int sum = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int ai = (int'(ta) >> (4 * i)) % 16;
        int bj = (int'(tb_) >> (4 * j)) % 16;
        int p  = ai * bj;
        int k  = i + j;
        int m  = (k == 0) ? int'(lo) : ((k == 2) ? int'(hi) : int'(mid));
        if (m == 1) p = p - (p % 4);
        if (m == 2) p = p - (p % 8);
        sum += p * (1 << (4 * k));
      end
    end
    return 16'(sum);
  endfunction

  task automatic cycle(input logic iv, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [1:0] lo, input logic [1:0] mid, input logic [1:0] hi,
                       input logic ordy, output logic acc);
    logic [15:0] e;
    int          t;
    @(negedge clk);
    in_valid = iv; a = ta; b = tb_;
    mode_lo = lo; mode_mid = mid; mode_hi = hi;
    out_ready = ordy;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_prod", prod, prev_prod);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_result", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        t = cyc_q.pop_front();
        last_lat  = cyc - t;
        last_prod = prod;
        check("prod", prod, e);
        check("prod_c4", {c4_out_valid, c4_prod}, {1'b1, e});
      end
    end
    acc = iv && in_ready && c4_in_ready;
    if (acc) begin
      exp_q.push_back(model(ta, tb_, lo, mid, hi));
      cyc_q.push_back(cyc);
      n_acc++;
    end
    prev_stall = out_valid && !out_ready;
    prev_prod  = prod;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_,
                      input logic [1:0] lo, input logic [1:0] mid, input logic [1:0] hi,
                      input logic ordy);
    logic acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cycle(1'b1, ta, tb_, lo, mid, hi, ordy, acc);
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, 8'h0, 8'h0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    cyc_q.delete();
    n_acc = 0;
    prev_stall = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_op_count", op_count, 16'd0);
    check("rst_prod", prod, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_op_count_c4", c4_op_count, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [7:0] d [4];
    logic       pend;
    logic [7:0] pa, pb;
    logic [1:0] plo, pmid, phi;

    do_reset();

    // Directed products and latency
    send(8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0, 1'b1);
    drain();
    check("p_ff_ff", last_prod, 16'hFE01);
    check("latency", last_lat, 3);
    send(8'h0F, 8'h0F, 2'd1, 2'd0, 2'd0, 1'b1);
    drain();
    check("p_lo_ap1", last_prod, 16'h00E0);
    send(8'h13, 8'h31, 2'd0, 2'd1, 2'd0, 1'b1);
    drain();
    check("p_mid_ap1", last_prod, 16'h0383);
    send(8'h30, 8'h30, 2'd0, 2'd0, 2'd2, 1'b1);
    drain();
    check("p_hi_ap2", last_prod, 16'h0800);
    send(8'hFF, 8'hFF, 2'd3, 2'd3, 2'd3, 1'b1);
    drain();
    check("p_rsv", last_prod, 16'hFE01);

    // Back-pressure: three beats fill the pipe, the fourth waits
    do_reset();
    d[0] = 8'h11; d[1] = 8'h5A; d[2] = 8'hC3; d[3] = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, d[i], ~d[i], 2'd0, 2'd1, 2'd2, 1'b0, acc);
      check("bp_accept", acc, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, d[3], ~d[3], 2'd0, 2'd1, 2'd2, 1'b0, acc);
      check("bp_stall_acc", acc, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
    end
    send(d[3], ~d[3], 2'd0, 2'd1, 2'd2, 1'b1);
    drain();
    check("bp_op_count", op_count, 16'd4);

    // Reset with beats in flight: nothing stale may emerge
    send(8'h21, 8'h43, 2'd0, 2'd0, 2'd0, 1'b1);
    send(8'h65, 8'h87, 2'd0, 2'd0, 2'd0, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h0, 8'h0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
      check("post_rst_idle", out_valid, 1'b0);
    end

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 20; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'd0, 2'd0, 2'd0, 1'b1);
    drain();
    check("sat_c4", c4_op_count, 4'd15);
    check("cnt_20", op_count, 16'd20);

    // Random traffic with random back-pressure; an offered beat is held until taken
    do_reset();
    pend = 1'b0;
    pa = '0; pb = '0; plo = '0; pmid = '0; phi = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        pa = 8'($urandom_range(0, 255));
        pb = 8'($urandom_range(0, 255));
        plo = 2'($urandom_range(0, 3));
        pmid = 2'($urandom_range(0, 3));
        phi = 2'($urandom_range(0, 3));
      end
      cycle(pend, pa, pb, plo, pmid, phi, ($urandom_range(0, 3) != 0), acc);
      if (acc) pend = 1'b0;
    end
    drain();
    check("rand_op_count", op_count, 16'(n_acc));
    check("rand_op_count_c4", c4_op_count, (n_acc > 15) ? 4'd15 : 4'(n_acc));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/acca_pipe.md
ACCA_PIPE -- requirements
Module: acca_pipe

Interface
REQ-001 Parameter N, default 8, operand width in bits; legal values 8, 12, 16 (multiple of 4); T = N/4 nibble tiles per operand.
REQ-002 Parameter CNT_W, default 16, width of the accepted-operation counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a  input  N  unsigned multiplicand.
REQ-008 b  input  N  unsigned multiplier.
REQ-009 mode_lo  input  2  mode for tile class k=0; sampled with the operands.
REQ-010 mode_mid  input  2  mode for tile classes 0<k<2(T-1).
REQ-011 mode_hi  input  2  mode for tile class k=2(T-1).
REQ-012 out_valid  output  1  prod valid.
REQ-013 out_ready  input  1  consumer accepts prod.
REQ-014 prod  output  2N  approximate unsigned product.
REQ-015 op_count  output  CNT_W  saturating count of accepted input beats.

Function
REQ-016 Tile (i,j) multiplies nibble i of a by nibble j of b; significance k=i+j; weighted by 2^(4k).
REQ-017 Tile modes: 0 EXACT p=ai*bj; 1 AP1 p with bits[1:0] forced 0; 2 AP2 p with bits[2:0] forced 0; 3 reserved, behaves as EXACT.
REQ-018 prod = exact sum of all weighted tile outputs, 2N bits; no overflow possible since each tile ≤ exact.
REQ-019 Pipeline: S1 registers a, b, modes; S2 registers all T*T tile outputs; S3 registers prod; latency 3 cycles from accepted beat to out_valid when out_ready held high.
REQ-020 advance = !out_valid || out_ready; all stages shift (valid bits included) when advance=1, all hold when 0.
REQ-021 in_ready = advance; beat accepted when in_valid && in_ready.
REQ-022 Bubbles are not collapsed; a stage holding no beat still occupies its slot.
REQ-023 While out_valid && !out_ready, prod SHALL remain stable.
REQ-024 Results emerge in acceptance order; one result per accepted beat; none dropped or duplicated.
REQ-025 Mode fields travel with their beat; changing mode inputs affects only later beats.
REQ-026 op_count increments by 1 per accepted beat and saturates at 2^CNT_W-1.
REQ-027 Throughput: one beat per cycle while out_ready=1.

Reset
REQ-028 On rst_n=0 at a clock edge: all stage valid bits 0, out_valid=0, op_count=0, prod=0, S1/S2 data registers 0.
REQ-029 Reset mid-operation discards all in-flight beats; no result of a pre-reset beat appears after reset.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-031 Shared package acca_pkg holds mode constants (MODE_EXACT=0, MODE_AP1=1, MODE_AP2=2, MODE_RSV=3) and the mode_t 2-bit typedef.
REQ-032 One sub-module, acca_tile4: combinational 4x4 unsigned multiplier with mode input implementing REQ-017, instantiated T*T times.
REQ-033 Tile mode selection by k and the adder tree live in acca_pipe; no other sub-modules.

Verification
REQ-034 N=8, all modes EXACT, a=0xFF, b=0xFF, out_ready=1 -> prod=0xFE01, out_valid exactly 3 cycles after acceptance.
REQ-035 N=8, mode_lo=AP1, others EXACT, a=0x0F, b=0x0F -> prod=0x00E0.
REQ-036 N=8, mode_mid=AP1, others EXACT, a=0x13, b=0x31 -> prod=0x0383 (exact 0x03A3); mode_hi=AP2, a=0x30, b=0x30 -> prod=0x0800.
REQ-037 out_ready=0, in_valid=1 with 4 distinct beats -> 3 accepted, then in_ready=0, prod stable; out_ready=1 -> 4 results in order, op_count=4.
REQ-038 rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0, op_count=0 next cycle; no stale results afterwards; in_ready=1.
REQ-039 CNT_W=4, 20 accepted beats -> op_count saturates at 15.
